// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational big-endian
// instruction memory and fills the IF/ID pipeline register. Handles load-use
// stalls, branch/jump redirects from ID, start/halt run control and faults.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_pc     enter RUN from IDLE/HALTED at start_pc
//   stall               hold PC and IF/ID for a load-use hazard
//   redirect_valid/_pc  taken branch/jump target from ID (overrides stall)
//   imem_pc/imem_instr  instruction memory address / returned word
//   if_id_*             registered instruction, its PC+4 and valid flag
//   running             fetch FSM is in RUN
//   fetch_fault         sticky alignment/range fault flag
//   fetch_count         instructions delivered to IF/ID (wrapping)
module fetch_stage #(
    parameter int unsigned MEM_BYTES    = 16384,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] start_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        running,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW      = 32;
    localparam logic [AW-1:0] LAST_PC = AW'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] pc_plus4_q, pc_plus4_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    logic [31:0]   count_q, count_d;

    logic [AW-1:0] pc_next_c;
    logic          pc_fault_c;
    logic          redir_bad_c;
    logic          zero_word_c;

    // Shared decode of the current fetch situation
    assign pc_next_c   = pc_q + AW'(4);
    assign pc_fault_c  = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);
    assign redir_bad_c = (redirect_pc[1:0] != 2'b00);
    assign zero_word_c = HALT_ON_ZERO && (imem_instr == 32'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fault beats redirect, redirect beats stall and halt
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (pc_fault_c) begin
                    state_d = HALTED;
                end else if (redirect_valid) begin
                    if (redir_bad_c) state_d = HALTED;
                end else if (!stall && zero_word_c) begin
                    state_d = HALTED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values, same priority order as the state transitions
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        count_d    = count_q;
        case (state_q)
            RUN: begin
                if (pc_fault_c) begin
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end else if (redirect_valid) begin
                    // Wrong-path flush: the word fetched this cycle is dropped
                    valid_d = 1'b0;
                    instr_d = 32'd0;
                    if (redir_bad_c) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (zero_word_c) begin
                    valid_d = 1'b0;
                end else begin
                    pc_d       = pc_next_c;
                    instr_d    = imem_instr;
                    pc_plus4_d = pc_next_c;
                    valid_d    = 1'b1;
                    count_d    = count_q + 32'd1;
                end
            end
            default: begin
                valid_d = 1'b0;
                if (start) begin
                    // Bad start PCs are loaded anyway and fault on the first RUN cycle
                    pc_d    = start_pc;
                    fault_d = 1'b0;
                end
            end
        endcase
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign imem_pc        = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc_plus4_q;
    assign if_id_valid    = valid_q;
    assign running        = (state_q == RUN);
    assign fetch_fault    = fault_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        running;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:16383];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_p4, m_cnt;
    logic        m_valid, m_run, m_fault;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_pc       (start_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .running        (running),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [13:0] i;
        i = a[13:0];
        if (a > 32'd16380) return 32'hFFFF_FFFF;
        return {mem[i], mem[i + 14'd1], mem[i + 14'd2], mem[i + 14'd3]};
    endfunction

    always_comb imem_instr = word_at(imem_pc);

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]     = w[31:24];
        mem[a + 1] = w[23:16];
        mem[a + 2] = w[15:8];
        mem[a + 3] = w[7:0];
    endtask

    task automatic fill_mem(input int zero_one_in);
        logic [31:0] w;
        for (int a = 0; a < 16384; a += 4) begin
            w = $urandom | 32'h0000_0001;
            if (zero_one_in > 0 && ($urandom % zero_one_in) == 0) w = 32'd0;
            put_word(a, w);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_p4 = 0; m_cnt = 0;
        m_valid = 0; m_run = 0; m_fault = 0;
    endtask

    // One clock edge of the fetch rules, using the inputs currently applied
    task automatic model_edge();
        logic [31:0] w;
        w = word_at(m_pc);
        if (!m_run) begin
            m_valid = 0;
            if (start) begin
                m_pc = start_pc; m_fault = 0; m_run = 1;
            end
        end else if (m_pc % 4 != 0 || m_pc > 32'd16380) begin
            m_fault = 1; m_valid = 0; m_run = 0;
        end else if (redirect_valid) begin
            m_valid = 0; m_instr = 0;
            if (redirect_pc % 4 != 0) begin
                m_fault = 1; m_run = 0;
            end else begin
                m_pc = redirect_pc;
            end
        end else if (stall) begin
            // everything held
        end else if (w == 0) begin
            m_run = 0; m_valid = 0;
        end else begin
            m_instr = w; m_p4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all();
        chk("imem_pc",        imem_pc,               m_pc);
        chk("if_id_instr",    if_id_instr,           m_instr);
        chk("if_id_pc_plus4", if_id_pc_plus4,        m_p4);
        chk("if_id_valid",    32'(if_id_valid),      32'(m_valid));
        chk("running",        32'(running),          32'(m_run));
        chk("fetch_fault",    32'(fetch_fault),      32'(m_fault));
        chk("fetch_count",    fetch_count,           m_cnt);
    endtask

    task automatic drive(input logic s, input logic [31:0] spc, input logic st,
                         input logic rv, input logic [31:0] rpc);
        start = s; start_pc = spc; stall = st; redirect_valid = rv; redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_reset_imem_pc", imem_pc, 32'd0);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] rpc, spc;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        fill_mem(0);
        put_word(100, 32'h4808_0000);
        put_word(1068, 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        #2 rst_n = 1'b1;

        // Start at 100 and take the first fetch
        @(negedge clk);
        drive(1, 100, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("first_instr", if_id_instr, 32'h4808_0000);
        chk("first_p4", if_id_pc_plus4, 32'd104);
        chk("first_count", fetch_count, 32'd1);

        // Move to 800, then stall two cycles at 804
        drive(0, 0, 0, 1, 800); step();
        drive(0, 0, 0, 0, 0);   step();
        drive(0, 0, 1, 0, 0);   step(); step();
        chk("stall_hold_pc", imem_pc, 32'd804);
        drive(0, 0, 0, 0, 0);   step();
        chk("resume_p4", if_id_pc_plus4, 32'd808);
        step();

        // Branch from 516 back to 500
        drive(0, 0, 0, 1, 516); step();
        drive(0, 0, 0, 0, 0);   step();
        drive(0, 0, 0, 1, 500); step();
        chk("branch_bubble", 32'(if_id_valid), 32'd0);
        drive(0, 0, 0, 0, 0);   step();
        chk("branch_refetch_p4", if_id_pc_plus4, 32'd504);

        // Jump at 1012 with stall also raised, then halt on the zero word at 1068
        drive(0, 0, 0, 1, 1012); step();
        drive(0, 0, 1, 1, 1064); step();
        chk("jump_pc", imem_pc, 32'd1064);
        drive(0, 0, 0, 0, 0);    step();
        chk("jump_p4", if_id_pc_plus4, 32'd1068);
        step();
        chk("halt_pc", imem_pc, 32'd1068);
        chk("halt_running", 32'(running), 32'd0);
        drive(0, 0, 1, 1, 40);   step();   // ignored while halted

        // Restart at 200, then misaligned redirect
        drive(1, 200, 0, 0, 0);  step();
        drive(0, 0, 0, 0, 0);    step(); step();
        drive(0, 0, 0, 1, 1066); step();
        chk("misaligned_fault", 32'(fetch_fault), 32'd1);
        drive(0, 0, 0, 0, 0);    step();

        // Out-of-range start faults on the first RUN cycle
        drive(1, 16384, 0, 0, 0); step();
        chk("oor_fault_clear", 32'(fetch_fault), 32'd0);
        drive(0, 0, 0, 0, 0);     step();
        chk("oor_fault", 32'(fetch_fault), 32'd1);

        // Start near the top so PC+4 walks out of range
        drive(1, 16376, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);     step(); step(); step();

        // Asynchronous reset in the middle of a run
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step(); step();
        async_reset_check();

        // Random traffic with occasional zero words
        fill_mem(40);
        for (int n = 0; n < 600; n++) begin
            rpc = 32'($urandom_range(0, 4095)) << 2;
            if ($urandom % 16 == 0) rpc = $urandom;
            spc = 32'($urandom_range(0, 4095)) << 2;
            if ($urandom % 10 == 0) spc = 32'($urandom_range(16370, 16400));
            drive($urandom % 5 == 0, spc, $urandom % 5 == 0, $urandom % 8 == 0, rpc);
            step();
            if (n == 300) async_reset_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the modified-MIPS pipeline.
- Owns the program counter and drives the byte address to the combinational, big-endian, 16 KB instruction memory.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles load-use stalls, branch/jump redirects from ID, run control and fetch faults.

Parameters:
- MEM_BYTES, 16384, instruction memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4.
- HALT_ON_ZERO, 1, when 1 an all-zero fetched word halts fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; loads start_pc and enters RUN from IDLE or HALTED.
- start_pc  in  32  initial PC sampled with start.
- stall  in  1  hazard-unit load-use stall; hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved in ID.
- redirect_pc  in  32  target address: branch = PC+4+(sext(imm16)<<2); jump = {PC+4[31:28],imm26,2'b00}.
- imem_pc  out  32  address to instruction memory; equals pc_q.
- imem_instr  in  32  word returned combinationally for imem_pc.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- running  out  1  state == RUN.
- fetch_fault  out  1  sticky fault flag.
- fetch_count  out  32  instructions delivered to IF/ID.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=0, state=IDLE.
  - if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0.
  - fetch_fault=0, fetch_count=0.
- FSM states: IDLE, RUN, HALTED.
- IDLE/HALTED:
  - PC held; if_id_valid=0; stall and redirect ignored.
  - start loads pc_q<=start_pc, clears fetch_fault and moves to RUN. fetch_count is not cleared.
  - If start_pc is misaligned or out of range, it is still loaded; the fault is raised in the next RUN cycle.
- RUN, evaluated each edge in priority order:
  1. Fault: pc_q[1:0]!=0 or pc_q>MEM_BYTES-4 -> fetch_fault<=1, if_id_valid<=0, state<=HALTED, PC held.
  2. Redirect (redirect_valid=1, wins over stall and halt):
     - If redirect_pc[1:0]!=0 -> fetch_fault<=1, state<=HALTED, PC held.
     - Otherwise pc_q<=redirect_pc.
     - In both cases if_id_valid<=0 and if_id_instr<=0 (wrong-path flush bubble).
  3. Stall: pc_q, if_id_* and fetch_count all held.
  4. Halt: HALT_ON_ZERO=1 and imem_instr==0 -> state<=HALTED, if_id_valid<=0, PC held at the zero word.
  5. Normal:
     - pc_q<=pc_q+4.
     - if_id_instr<=imem_instr, if_id_pc_plus4<=pc_q+4, if_id_valid<=1.
     - fetch_count<=fetch_count+1 (wraps modulo 2^32).
- Latency: a word at pc_q appears on if_id_* one cycle after the edge where pc_q is presented and not stalled.
- start while in RUN is ignored.
- PC arithmetic is 32-bit unsigned, wrapping; the range check catches any wrap.
- rst_n mid-operation: everything returns to reset values immediately, not on the next edge.
- Only one redirect is accepted per cycle. A redirect during the stall that the hazard unit raised is legal and overrides the stall.

Test Plan:
- Reset, then start with start_pc=100, imem returning 0x48080000 at 100 -> next edge: if_id_instr=0x48080000, if_id_pc_plus4=104, if_id_valid=1, imem_pc=104, fetch_count=1.
- Stall high 2 cycles at pc=804 -> imem_pc stays 804, if_id_* unchanged, fetch_count unchanged; on release, fetch resumes at 804 then 808.
- Jump redirect_pc=1064 at PC 1012 with stall also high -> imem_pc=1064 next cycle, if_id_valid=0 for one cycle, then if_id_instr=word at 1064, if_id_pc_plus4=1068.
- Branch redirect_pc=500 (beq -5 from 516) -> bubble inserted, then refetch from 500.
- Fetch zero word at 1068 -> running=0, if_id_valid=0, imem_pc stays 1068; a later start with start_pc=200 resumes fetching at 200.
- Redirect to 1066 (misaligned) -> fetch_fault=1, state HALTED; separately, start_pc=16384 -> fault on first RUN cycle; rst_n low mid-run -> all outputs zero asynchronously.
